mdio_target: RTL and testbench

MDIO Clause 22 target (responder) for the management plane: sits on an MDIO bus driven by an external station manager and exposes a 32 x 16-bit register space to fabric logic through strobed read/write ports. It is the far end of the protocol our APB MDIO controller initiates. Typical uses are emulated PHY registers for a board-management MCU or a loopback target for verifying the controller.

---
 rtl/mdio_target_pkg.sv | 32 +++
 rtl/mdio_target_sync.sv | 39 +++
 rtl/mdio_target.sv | 226 ++++++++++++++++++++++
 tb/tb_mdio_target.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_target_pkg.sv
// mdio_target_pkg: shared definitions for the MDIO Clause 22 target.
//   - ST and opcode field values
//   - frame field lengths, as down-counter load values
//   - FSM state encoding
`timescale 1ns/1ps
package MdioPkg;

    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;

    // bit_cnt is loaded with (bits remaining - 1) and counts down to 0.
    localparam logic [4:0] CNT_OP          = 5'd1;   // 2 opcode bits
    localparam logic [4:0] CNT_ADDR        = 5'd4;   // 5 PHYAD / REGAD bits
    localparam logic [4:0] CNT_TA          = 5'd1;   // 2 turnaround bits
    localparam logic [4:0] CNT_WR_DATA     = 5'd15;  // 16 data bits
    localparam logic [4:0] CNT_RD_DATA     = 5'd16;  // 16 driven bits + release rise
    localparam logic [4:0] CNT_SKIP_OP     = 5'd27;  // PHYAD + REGAD + TA + DATA
    localparam logic [4:0] CNT_SKIP_REGAD  = 5'd17;  // TA + DATA

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OP,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_DATA,
        ST_SKIP
    } mdio_state_e;

endpackage

// File: rtl/mdio_target_sync.sv
// mdio_target_sync: brings mdc and mdio_in into the clk domain and produces
// a one-cycle strobe on each rising edge of the synchronized mdc.
//   clk, rst_n  : system clock, async active-low reset
//   mdc         : MDIO clock pin (asynchronous)
//   mdio_in     : MDIO data pin (asynchronous)
//   mdc_rise    : high for one clk when synchronized mdc goes 0 -> 1
//   mdio_bit    : synchronized mdio_in, valid to sample while mdc_rise is high
`timescale 1ns/1ps
module mdio_target_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdio_in,
    output logic mdc_rise,
    output logic mdio_bit
);

    logic [1:0] mdc_ff;
    logic [1:0] mdio_ff;
    logic       mdc_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_ff   <= '0;
            mdio_ff  <= '0;
            mdc_prev <= 1'b0;
        end else begin
            mdc_ff   <= {mdc_ff[0], mdc};
            mdio_ff  <= {mdio_ff[0], mdio_in};
            mdc_prev <= mdc_ff[1];
        end
    end

    // Both pins travel through matching 2-FF chains, so the data bit seen with
    // the strobe is the one the station set up before its mdc rise.
    assign mdc_rise = mdc_ff[1] & ~mdc_prev;
    assign mdio_bit = mdio_ff[1];

endmodule

// File: rtl/mdio_target.sv
// mdio_target: MDIO Clause 22 responder exposing 32 x 16-bit registers to
// fabric logic through strobed read/write ports.
//   clk, rst_n        : system clock (>= 16x mdc), async active-low reset
//   mdc, mdio_in      : MDIO bus pins from the station manager
//   mdio_out, mdio_oe : registered pad drive value and enable
//   rd_en, rd_addr    : one-cycle read request; rd_data sampled at first TA rise
//   wr_en, wr_addr,
//   wr_data           : one-cycle write strobe; addr/data hold until next write
//   busy              : frame in progress (start bit seen, not yet back in IDLE)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | counting preamble ones, waiting for the ST 0 bit
// START    | expecting ST second bit (1); 0 means Clause 45, abandon
// OP       | shifting two opcode bits
// PHYAD    | shifting five PHY address bits
// REGAD    | shifting five register address bits, decide respond/skip
// TA       | turnaround; read drives 0 from the first TA rise
// DATA     | 16 data bits, shifted in (write) or driven out (read)
// SKIP     | passive, counting out the rest of a frame not for us
`timescale 1ns/1ps
module mdio_target
    import MdioPkg::*;
#(
    parameter logic [4:0] PHY_ADDR      = 5'd0,
    parameter int         PREAMBLE_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic        rd_en,
    output logic [4:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        busy
);

    localparam int PRE_W = (PREAMBLE_BITS < 1) ? 1 : $clog2(PREAMBLE_BITS + 1);
    localparam logic [PRE_W-1:0] PRE_SAT = PRE_W'(PREAMBLE_BITS);

    mdio_state_e      state;
    mdio_state_e      state_nxt;
    logic [4:0]       bit_cnt;
    logic [PRE_W-1:0] pre_cnt;
    logic             op_msb;
    logic             is_read;
    logic [4:0]       phy_sh;
    logic [4:0]       reg_sh;
    logic [15:0]      data_sh;

    logic mdc_rise;
    logic mdio_bit;
    logic cnt_done;
    logic phy_match;
    logic oe_nxt;
    logic out_nxt;
    logic rd_en_nxt;
    logic wr_en_nxt;

    mdio_target_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc      (mdc),
        .mdio_in  (mdio_in),
        .mdc_rise (mdc_rise),
        .mdio_bit (mdio_bit)
    );

    assign cnt_done  = (bit_cnt == 5'd0);
    assign phy_match = (phy_sh == PHY_ADDR);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state
    always_comb begin
        state_nxt = state;
        if (mdc_rise) begin
            case (state)
                ST_IDLE:  if (!mdio_bit && pre_cnt == PRE_SAT) state_nxt = ST_START;
                ST_START: state_nxt = (mdio_bit == MDIO_ST[0]) ? ST_OP : ST_IDLE;
                ST_OP: begin
                    if (cnt_done) begin
                        if ({op_msb, mdio_bit} == MDIO_OP_READ ||
                            {op_msb, mdio_bit} == MDIO_OP_WRITE) begin
                            state_nxt = ST_PHYAD;
                        end else begin
                            state_nxt = ST_SKIP;
                        end
                    end
                end
                ST_PHYAD: if (cnt_done) state_nxt = ST_REGAD;
                ST_REGAD: if (cnt_done) state_nxt = phy_match ? ST_TA : ST_SKIP;
                // A read leaves TA after its first rise; the second TA rise
                // already drives data[15] from the DATA state.
                ST_TA:    if (is_read || cnt_done) state_nxt = ST_DATA;
                ST_DATA:  if (cnt_done) state_nxt = ST_IDLE;
                ST_SKIP:  if (cnt_done) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // outputs: busy directly, pad drive and strobes as next values for registers
    always_comb begin
        busy      = (state != ST_IDLE);
        oe_nxt    = mdio_oe;
        out_nxt   = mdio_out;
        rd_en_nxt = 1'b0;
        wr_en_nxt = 1'b0;
        if (mdc_rise) begin
            case (state)
                ST_REGAD: rd_en_nxt = cnt_done && phy_match && is_read;
                ST_TA: begin
                    if (is_read) begin
                        oe_nxt  = 1'b1;
                        out_nxt = 1'b0;
                    end
                end
                ST_DATA: begin
                    if (is_read) begin
                        if (cnt_done) begin
                            oe_nxt  = 1'b0;
                            out_nxt = 1'b0;
                        end else begin
                            out_nxt = data_sh[15];
                        end
                    end else begin
                        wr_en_nxt = cnt_done;
                    end
                end
                default: ;
            endcase
        end
    end

    // datapath: counters, shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            pre_cnt  <= '0;
            op_msb   <= 1'b0;
            is_read  <= 1'b0;
            phy_sh   <= '0;
            reg_sh   <= '0;
            data_sh  <= '0;
            mdio_oe  <= 1'b0;
            mdio_out <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            mdio_oe  <= oe_nxt;
            mdio_out <= out_nxt;
            rd_en    <= rd_en_nxt;
            wr_en    <= wr_en_nxt;

            // Every frame must be preceded by a fresh preamble.
            if (state != ST_IDLE) pre_cnt <= '0;

            if (mdc_rise) begin
                if (!cnt_done) bit_cnt <= bit_cnt - 5'd1;
                case (state)
                    ST_IDLE: begin
                        if (!mdio_bit)               pre_cnt <= '0;
                        else if (pre_cnt != PRE_SAT) pre_cnt <= pre_cnt + 1'b1;
                    end
                    ST_START: bit_cnt <= CNT_OP;
                    ST_OP: begin
                        op_msb <= mdio_bit;
                        if (cnt_done) begin
                            is_read <= ({op_msb, mdio_bit} == MDIO_OP_READ);
                            if ({op_msb, mdio_bit} == MDIO_OP_READ ||
                                {op_msb, mdio_bit} == MDIO_OP_WRITE) begin
                                bit_cnt <= CNT_ADDR;
                            end else begin
                                bit_cnt <= CNT_SKIP_OP;
                            end
                        end
                    end
                    ST_PHYAD: begin
                        phy_sh <= {phy_sh[3:0], mdio_bit};
                        if (cnt_done) bit_cnt <= CNT_ADDR;
                    end
                    ST_REGAD: begin
                        reg_sh <= {reg_sh[3:0], mdio_bit};
                        if (cnt_done) begin
                            bit_cnt <= phy_match ? CNT_TA : CNT_SKIP_REGAD;
                            if (phy_match && is_read) rd_addr <= {reg_sh[3:0], mdio_bit};
                        end
                    end
                    ST_TA: begin
                        if (is_read) begin
                            data_sh <= rd_data;
                            bit_cnt <= CNT_RD_DATA;
                        end else if (cnt_done) begin
                            bit_cnt <= CNT_WR_DATA;
                        end
                    end
                    ST_DATA: begin
                        data_sh <= {data_sh[14:0], is_read ? 1'b0 : mdio_bit};
                        if (!is_read && cnt_done) begin
                            wr_addr <= reg_sh;
                            wr_data <= {data_sh[14:0], mdio_bit};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_target.sv
// tb_mdio_target: station-manager model driving MDIO frames into mdio_target,
// a small fabric register file behind the strobe ports, and a strobe
// scoreboard fed by the frame stimulus.
`timescale 1ns/1ps
module tb_mdio_target;
    import MdioPkg::*;

    localparam int HALF = 80;   // mdc half period: 8 clk

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mdc;
    logic        mdio_in;
    logic        mdio_out, mdio_oe, rd_en, wr_en, busy;
    logic [4:0]  rd_addr, wr_addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;

    logic        np_out, np_oe, np_rd_en, np_wr_en, np_busy;
    logic [4:0]  np_rd_addr, np_wr_addr;
    logic [15:0] np_wr_data;

    always #5 clk = ~clk;

    mdio_target #(.PHY_ADDR(5'd0), .PREAMBLE_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_in(mdio_in),
        .mdio_out(mdio_out), .mdio_oe(mdio_oe),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    mdio_target #(.PHY_ADDR(5'd0), .PREAMBLE_BITS(0)) dut_nopre (
        .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_in(mdio_in),
        .mdio_out(np_out), .mdio_oe(np_oe),
        .rd_en(np_rd_en), .rd_addr(np_rd_addr), .rd_data(rd_data),
        .wr_en(np_wr_en), .wr_addr(np_wr_addr), .wr_data(np_wr_data), .busy(np_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // fabric register file; register 0x1F is a read-only ID
    logic [15:0] mem [32];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= (rd_addr == 5'h1F) ? 16'hBEEF : mem[rd_addr];
    end

    typedef struct {
        logic        is_wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] rword_q[$];
    exp_t        mon_e;
    int          both_cnt = 0;
    int          np_wr_cnt = 0;

    always @(negedge clk) begin
        if (rd_en && wr_en) both_cnt++;
        if (np_wr_en) np_wr_cnt++;
        if (rst_n && (rd_en || wr_en)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'({wr_en, rd_en}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_kind", 32'(wr_en), 32'(mon_e.is_wr));
                if (wr_en) begin
                    chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                    chk("wr_data", 32'(wr_data), 32'(mon_e.data));
                end else begin
                    chk("rd_addr", 32'(rd_addr), 32'(mon_e.addr));
                end
            end
        end
    end

    // One frame as the station sees it. Line is sampled just before each mdc
    // rise. Period p is the p-th bit after the preamble (ST = 1,2 ... DATA = 17..32).
    task automatic run_frame(input int n_pre, input logic [1:0] st, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] regad,
                             input logic [15:0] wdata, input int rst_period,
                             output logic [15:0] rword, output int oe_ctrl,
                             output int oe_data, output logic ta_ok,
                             output logic busy_mid, output logic oe_rst);
        logic [31:0] vec;
        logic        rd;
        logic        so;
        logic        sout;
        rd = (st == MDIO_ST) && (op == MDIO_OP_READ);
        vec = {st, op, phy, regad, rd ? 2'b11 : 2'b10, rd ? 16'hFFFF : wdata};
        rword = '0; oe_ctrl = 0; oe_data = 0; ta_ok = 1'b0; busy_mid = 1'b0; oe_rst = 1'b1;
        for (int i = 0; i < n_pre; i++) begin
            mdc = 1'b0; mdio_in = 1'b1; #(HALF);
            if (mdio_oe) oe_ctrl++;
            mdc = 1'b1; #(HALF);
        end
        for (int p = 1; p <= 32; p++) begin
            mdc = 1'b0; mdio_in = vec[32-p]; #(HALF);
            so = mdio_oe; sout = mdio_out;
            if (p == 10) busy_mid = busy;
            if (p == 16) ta_ok = so && !sout;
            else if (p >= 17) begin
                if (so) oe_data++;
                rword = {rword[14:0], sout};
            end else if (so) oe_ctrl++;
            if (p == rst_period) begin
                rst_n = 1'b0;
                #1;
                oe_rst = mdio_oe;
                return;
            end
            mdc = 1'b1; #(HALF);
        end
        // idle period after the frame: drive must already be released
        mdc = 1'b0; mdio_in = 1'b1; #(HALF);
        if (mdio_oe) oe_ctrl++;
        mdc = 1'b1; #(HALF);
    endtask

    task automatic xact(input string name, input int n_pre, input logic [1:0] st,
                        input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regad,
                        input logic [15:0] data, input bit hit);
        logic [15:0] rword;
        int          oe_ctrl;
        int          oe_data;
        logic        ta_ok;
        logic        busy_mid;
        logic        oe_rst;
        bit          is_rd;
        is_rd = hit && (op == MDIO_OP_READ);
        if (hit) begin
            exp_q.push_back('{is_wr: !is_rd, addr: regad, data: data});
            if (is_rd) rword_q.push_back(data);
        end
        run_frame(n_pre, st, op, phy, regad, data, 0, rword, oe_ctrl, oe_data, ta_ok, busy_mid, oe_rst);
        chk({name, "_oe_ctrl"}, 32'(oe_ctrl), 32'd0);
        if (is_rd) begin
            chk({name, "_ta"}, 32'(ta_ok), 32'd1);
            chk({name, "_oe_data"}, 32'(oe_data), 32'd16);
            chk({name, "_rword"}, 32'(rword), 32'(rword_q.pop_front()));
        end else begin
            chk({name, "_ta"}, 32'(ta_ok), 32'd0);
            chk({name, "_oe_data"}, 32'(oe_data), 32'd0);
        end
        if (hit) chk({name, "_busy_mid"}, 32'(busy_mid), 32'd1);
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : main
        logic [15:0] rword;
        int          oe_ctrl;
        int          oe_data;
        logic        ta_ok;
        logic        busy_mid;
        logic        oe_rst;
        int          np_before;

        rst_n = 1'b0; mdc = 1'b0; mdio_in = 1'b1;
        #100;
        chk("rst_mdio_oe",  32'(mdio_oe),  32'd0);
        chk("rst_mdio_out", 32'(mdio_out), 32'd0);
        chk("rst_rd_en",    32'(rd_en),    32'd0);
        chk("rst_rd_addr",  32'(rd_addr),  32'd0);
        chk("rst_wr_en",    32'(wr_en),    32'd0);
        chk("rst_wr_addr",  32'(wr_addr),  32'd0);
        chk("rst_wr_data",  32'(wr_data),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);

        xact("wr04",  32, MDIO_ST, MDIO_OP_WRITE, 5'd0, 5'h04, 16'hA5C3, 1'b1);
        xact("rd1f",  32, MDIO_ST, MDIO_OP_READ,  5'd0, 5'h1F, 16'hBEEF, 1'b1);
        xact("rd04",  32, MDIO_ST, MDIO_OP_READ,  5'd0, 5'h04, 16'hA5C3, 1'b1);
        xact("phy3",  32, MDIO_ST, MDIO_OP_WRITE, 5'd3, 5'h05, 16'hFFFF, 1'b0);
        xact("b2b07", 32, MDIO_ST, MDIO_OP_WRITE, 5'd0, 5'h07, 16'h5A0F, 1'b1);

        np_before = np_wr_cnt;
        xact("short_pre", 20, MDIO_ST, MDIO_OP_WRITE, 5'd0, 5'h0A, 16'h1234, 1'b0);
        chk("nopre_wr_cnt",  32'(np_wr_cnt - np_before), 32'd1);
        chk("nopre_wr_addr", 32'(np_wr_addr), 32'h0A);
        chk("nopre_wr_data", 32'(np_wr_data), 32'h1234);

        xact("op11", 32, MDIO_ST, 2'b11, 5'd0, 5'h07, 16'h1111, 1'b0);
        xact("op00", 32, MDIO_ST, 2'b00, 5'd0, 5'h07, 16'h2222, 1'b0);
        xact("c45",  32, 2'b00, MDIO_OP_WRITE, 5'd0, 5'h07, 16'h2222, 1'b0);
        xact("rd07", 32, MDIO_ST, MDIO_OP_READ, 5'd0, 5'h07, 16'h5A0F, 1'b1);

        // reset in the low half after data bit 8 has been on the line
        exp_q.push_back('{is_wr: 1'b0, addr: 5'h1F, data: 16'h0000});
        rword_q.push_back(16'h00BE);
        run_frame(32, MDIO_ST, MDIO_OP_READ, 5'd0, 5'h1F, 16'h0000, 24,
                  rword, oe_ctrl, oe_data, ta_ok, busy_mid, oe_rst);
        chk("rst_mid_oe_before", 32'(oe_data), 32'd8);
        chk("rst_mid_oe_after",  32'(oe_rst),  32'd0);
        chk("rst_mid_rword",     32'(rword),   32'(rword_q.pop_front()));
        chk("rst_mid_busy",      32'(busy),    32'd0);
        chk("rst_mid_pending",   32'(exp_q.size()), 32'd0);
        #200;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);

        xact("wr1e", 32, MDIO_ST, MDIO_OP_WRITE, 5'd0, 5'h1E, 16'hC0DE, 1'b1);
        xact("rd1e", 32, MDIO_ST, MDIO_OP_READ,  5'd0, 5'h1E, 16'hC0DE, 1'b1);

        chk("rd_wr_same_cycle", 32'(both_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
